// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// PS2ScancodeDecoder
//
// Purpose:
//   Turns a stream of PS/2 set-2 scancode bytes into ASCII characters and
//   buffers them in a small show-ahead FIFO for a consumer.
//
//   A four-state prefix FSM (IDLE, E0, F0, E0F0) classifies every byte as a
//   make, extended make, break or extended break. Make codes are translated
//   through a US-layout table. The translation takes the shift and ctrl
//   modifier registers into account; left and right keys are tracked
//   separately. The translated byte is registered one cycle after its
//   scancode strobe and written into the FIFO on the cycle after that.
//
// Parameters:
//   FIFO_DEPTH      number of ASCII bytes buffered (power of two, 2..64)
//
// Ports:
//   CLOCK_50        system clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   scancode        set-2 byte from the keyboard receiver
//   scancode_ready  one-cycle strobe qualifying scancode
//   key_data        ASCII byte at the FIFO head, 8'h00 when empty
//   key_valid       high while the FIFO holds at least one byte
//   key_pop         removes the head byte; ignored when empty
//   fifo_full       high while the FIFO holds FIFO_DEPTH bytes
//   overflow        sticky flag, a translated byte was dropped (full FIFO)
//
// Configuration:
//   KBD_CAPS_LOCK_EN  when defined, make 8'h58 toggles a caps-lock register
//                     and letters are upper-case when caps XOR shift.
//                     When undefined, 8'h58 is just an unmapped make.
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [7:0] scancode,
    input  logic       scancode_ready,
    output logic [7:0] key_data,
    output logic       key_valid,
    input  logic       key_pop,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        E0,
        F0,
        E0F0
    } state_t;

    state_t      r_state;
    logic        r_shiftL;
    logic        r_shiftR;
    logic        r_ctrlL;
    logic        r_ctrlR;
    logic        r_xlatValid;
    logic [7:0]  r_xlatData;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic        r_overflow;

    logic        w_isE0;
    logic        w_isF0;
    logic        w_ignored;
    logic        w_make;
    logic        w_extMake;
    logic        w_break;
    logic        w_extBreak;
    logic        w_shift;
    logic        w_ctrl;
    logic        w_capsActive;
    logic [17:0] w_lookup;
    logic        w_xlatValid;
    logic [7:0]  w_xlatData;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    // US-layout table for normal make codes.
    // Result packing: {hit, isLetter, unshifted ASCII, shifted ASCII}.
    function automatic logic [17:0] lookup(input logic [7:0] code);
        logic [17:0] f;
        case (code)
            8'h1C: f = {2'b11, "a", "A"};
            8'h32: f = {2'b11, "b", "B"};
            8'h21: f = {2'b11, "c", "C"};
            8'h23: f = {2'b11, "d", "D"};
            8'h24: f = {2'b11, "e", "E"};
            8'h2B: f = {2'b11, "f", "F"};
            8'h34: f = {2'b11, "g", "G"};
            8'h33: f = {2'b11, "h", "H"};
            8'h43: f = {2'b11, "i", "I"};
            8'h3B: f = {2'b11, "j", "J"};
            8'h42: f = {2'b11, "k", "K"};
            8'h4B: f = {2'b11, "l", "L"};
            8'h3A: f = {2'b11, "m", "M"};
            8'h31: f = {2'b11, "n", "N"};
            8'h44: f = {2'b11, "o", "O"};
            8'h4D: f = {2'b11, "p", "P"};
            8'h15: f = {2'b11, "q", "Q"};
            8'h2D: f = {2'b11, "r", "R"};
            8'h1B: f = {2'b11, "s", "S"};
            8'h2C: f = {2'b11, "t", "T"};
            8'h3C: f = {2'b11, "u", "U"};
            8'h2A: f = {2'b11, "v", "V"};
            8'h1D: f = {2'b11, "w", "W"};
            8'h22: f = {2'b11, "x", "X"};
            8'h35: f = {2'b11, "y", "Y"};
            8'h1A: f = {2'b11, "z", "Z"};
            8'h45: f = {2'b10, "0", ")"};
            8'h16: f = {2'b10, "1", "!"};
            8'h1E: f = {2'b10, "2", "@"};
            8'h26: f = {2'b10, "3", "#"};
            8'h25: f = {2'b10, "4", "$"};
            8'h2E: f = {2'b10, "5", "%"};
            8'h36: f = {2'b10, "6", "^"};
            8'h3D: f = {2'b10, "7", "&"};
            8'h3E: f = {2'b10, "8", "*"};
            8'h46: f = {2'b10, "9", "("};
            8'h4E: f = {2'b10, "-", "_"};
            8'h55: f = {2'b10, "=", "+"};
            8'h54: f = {2'b10, "[", "{"};
            8'h5B: f = {2'b10, "]", "}"};
            8'h4C: f = {2'b10, ";", ":"};
            8'h52: f = {2'b10, "'", "\""};
            8'h41: f = {2'b10, ",", "<"};
            8'h49: f = {2'b10, ".", ">"};
            8'h4A: f = {2'b10, "/", "?"};
            8'h0E: f = {2'b10, 8'h60, "~"};
            8'h5D: f = {2'b10, "\\", "|"};
            8'h29: f = {2'b10, 8'h20, 8'h20};
            8'h5A: f = {2'b10, 8'h0D, 8'h0D};
            8'h66: f = {2'b10, 8'h08, 8'h08};
            8'h76: f = {2'b10, 8'h1B, 8'h1B};
            8'h0D: f = {2'b10, 8'h09, 8'h09};
            default: f = 18'h0;
        endcase
        return f;
    endfunction

    // Classify the incoming byte against the current prefix state. Exactly
    // one of make/extMake/break/extBreak can fire, and only on a strobe.
    always_comb begin
        w_isE0     = (scancode == 8'hE0);
        w_isF0     = (scancode == 8'hF0);
        w_ignored  = (scancode == 8'hAA) || (scancode == 8'hFA) ||
                     (scancode == 8'hFE) || (scancode == 8'h00) ||
                     (scancode == 8'hFF);
        w_make     = scancode_ready && (r_state == IDLE) &&
                     !w_isE0 && !w_isF0 && !w_ignored;
        w_extMake  = scancode_ready && (r_state == E0) && !w_isE0 && !w_isF0;
        w_break    = scancode_ready && (r_state == F0) && !w_isF0;
        w_extBreak = scancode_ready && (r_state == E0F0);
    end

    assign w_shift = r_shiftL | r_shiftR;
    assign w_ctrl  = r_ctrlL | r_ctrlR;

`ifdef KBD_CAPS_LOCK_EN
    logic r_caps;

    // Caps lock flips on each make of 8'h58; its break is simply ignored.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_caps <= 1'b0;
        end else if (w_make && (scancode == 8'h58)) begin
            r_caps <= ~r_caps;
        end
    end

    assign w_capsActive = r_caps;
`else
    assign w_capsActive = 1'b0;
`endif

    // Translate a make into ASCII. Ctrl only affects letters and beats
    // shift; caps lock only affects letters.
    always_comb begin
        w_lookup    = lookup(scancode);
        w_xlatValid = 1'b0;
        w_xlatData  = 8'h00;
        if (w_make && w_lookup[17]) begin
            w_xlatValid = 1'b1;
            if (w_lookup[16] && w_ctrl) begin
                w_xlatData = w_lookup[7:0] & 8'h1F;
            end else if (w_lookup[16]) begin
                w_xlatData = (w_shift ^ w_capsActive) ? w_lookup[7:0] : w_lookup[15:8];
            end else begin
                w_xlatData = w_shift ? w_lookup[7:0] : w_lookup[15:8];
            end
        end else if (w_extMake && (scancode == 8'h5A)) begin
            w_xlatValid = 1'b1;
            w_xlatData  = 8'h0D;
        end
    end

    // Prefix FSM, modifier tracking and the translation register. The
    // modifiers change on the same edge that registers a translation, so a
    // modifier make only influences the bytes that follow it.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shiftL    <= 1'b0;
            r_shiftR    <= 1'b0;
            r_ctrlL     <= 1'b0;
            r_ctrlR     <= 1'b0;
            r_xlatValid <= 1'b0;
            r_xlatData  <= 8'h00;
        end else begin
            r_xlatValid <= w_xlatValid;
            r_xlatData  <= w_xlatData;

            if (scancode_ready) begin
                case (r_state)
                    IDLE: begin
                        if (w_isE0) begin
                            r_state <= E0;
                        end else if (w_isF0) begin
                            r_state <= F0;
                        end
                    end
                    E0: begin
                        if (w_isF0) begin
                            r_state <= E0F0;
                        end else if (!w_isE0) begin
                            r_state <= IDLE;
                        end
                    end
                    F0: begin
                        if (!w_isF0) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end

            if (w_make && (scancode == 8'h12)) r_shiftL <= 1'b1;
            if (w_break && (scancode == 8'h12)) r_shiftL <= 1'b0;
            if (w_make && (scancode == 8'h59)) r_shiftR <= 1'b1;
            if (w_break && (scancode == 8'h59)) r_shiftR <= 1'b0;
            if (w_make && (scancode == 8'h14)) r_ctrlL <= 1'b1;
            if (w_break && (scancode == 8'h14)) r_ctrlL <= 1'b0;
            if (w_extMake && (scancode == 8'h14)) r_ctrlR <= 1'b1;
            if (w_extBreak && (scancode == 8'h14)) r_ctrlR <= 1'b0;
        end
    end

    // A push into a full FIFO is still accepted when a pop frees a slot on
    // the same edge.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = key_pop && !w_empty;
    assign w_push  = r_xlatValid && (!w_full || w_pop);

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (r_xlatValid && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Storage has no reset; stale entries are never visible because the
    // head is gated by the occupancy count.
    always_ff @(posedge CLOCK_50) begin
        if (!rst && w_push) begin
            r_mem[r_wrPtr] <= r_xlatData;
        end
    end

    assign key_valid = !w_empty;
    assign key_data  = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign fifo_full = w_full;
    assign overflow  = r_overflow;

endmodule
